// File: rtl/mmio_gpio_pkg.sv
// mmio_gpio_pkg: shared sizing helpers and region decode type for the
// memory-mapped GPIO block (mmio_gpio).
package mmio_gpio_pkg;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_OUT,
    REGION_IN,
    REGION_EDGE
  } region_e;

  localparam int unsigned OUT_BASE_WORD = 0;

  // Number of XLEN-wide words needed to hold len bits.
  function automatic int unsigned words(input int unsigned len, input int unsigned xlen);
    return (len + xlen - 1) / xlen;
  endfunction

  // First word offset of the read-only debounced input region.
  function automatic int unsigned in_base_word(input int unsigned out_len, input int unsigned xlen);
    return OUT_BASE_WORD + words(out_len, xlen);
  endfunction

  // First word offset of the write-1-to-clear edge capture region.
  function automatic int unsigned edge_base_word(input int unsigned out_len,
                                                 input int unsigned in_len,
                                                 input int unsigned xlen);
    return in_base_word(out_len, xlen) + words(in_len, xlen);
  endfunction

  // Counter width able to hold 0..cycles-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/mmio_gpio_debounce.sv
// mmio_gpio_debounce: one input pin through a 2-flop synchronizer, then an
// acceptance stage producing the stable level and a one-cycle rise pulse.
// With MMIO_GPIO_DEBOUNCE_EN defined, a change must persist for
// DEBOUNCE_CYCLES cycles at the synchronizer output before it is accepted;
// otherwise the synchronized level is accepted every cycle.
module mmio_gpio_debounce
  import mmio_gpio_pkg::*;
`ifdef MMIO_GPIO_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise
);

  logic s1;
  logic s2;
  logic accept;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef MMIO_GPIO_DEBOUNCE_EN
  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Accept once the mismatch has been seen for DEBOUNCE_CYCLES cycles.
  always_comb begin
    accept = (s2 != stable) && (cnt == CNT_LAST);
  end

  // Mismatch-duration counter; restarts on agreement or acceptance.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if ((s2 == stable) || accept) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // Without debouncing every synchronized change is accepted at once.
  always_comb begin
    accept = (s2 != stable);
  end
`endif

  // Accepted input level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stable <= 1'b0;
    end else if (accept) begin
      stable <= s2;
    end
  end

  // Rise is asserted on the edge where a 0->1 acceptance takes effect.
  always_comb begin
    rise = accept && s2;
  end

endmodule

// File: rtl/mmio_gpio.sv
// mmio_gpio: word-decoded GPIO block at IO_BASE_ADDR. Regions in order:
// OUT (R/W output latch), IN (RO debounced inputs), EDGE (W1C rising-edge
// capture, ORed onto irq). Optional macro MMIO_GPIO_DEBOUNCE_EN enables the
// per-pin debounce counters.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int unsigned     XLEN              = 32,
  parameter int unsigned     IO_INPUT_BUS_LEN  = 14,
  parameter int unsigned     IO_OUTPUT_BUS_LEN = 52,
  parameter logic [XLEN-1:0] IO_BASE_ADDR      = 'h60,
  parameter int unsigned     DEBOUNCE_CYCLES   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [XLEN-1:0]              mem_addr,
  input  logic [XLEN-1:0]              mem_wdata,
  input  logic [XLEN/8-1:0]            mem_wstrb,
  input  logic                         mem_we,
  output logic [XLEN-1:0]              mem_rdata,
  output logic                         mem_hit,
  input  logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
  output logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus,
  output logic                         irq
);

  localparam int unsigned IN_BASE    = in_base_word(IO_OUTPUT_BUS_LEN, XLEN);
  localparam int unsigned EDGE_BASE  = edge_base_word(IO_OUTPUT_BUS_LEN, IO_INPUT_BUS_LEN, XLEN);
  localparam int unsigned NW         = EDGE_BASE + words(IO_INPUT_BUS_LEN, XLEN);
  localparam int unsigned LANE_SHIFT = $clog2(XLEN / 8);

  logic [XLEN-1:0]              offset;
  logic [XLEN-1:0]              word_idx;
  region_e                      region;
  logic                         wr;
  logic [IO_OUTPUT_BUS_LEN-1:0] out_q;
  logic [IO_OUTPUT_BUS_LEN-1:0] out_d;
  logic [IO_INPUT_BUS_LEN-1:0]  stable;
  logic [IO_INPUT_BUS_LEN-1:0]  rise;
  logic [IO_INPUT_BUS_LEN-1:0]  edge_q;
  logic [IO_INPUT_BUS_LEN-1:0]  edge_clr;

  // Per-pin synchronizer / debounce / rise detection.
  for (genvar g = 0; g < IO_INPUT_BUS_LEN; g++) begin : g_in
`ifdef MMIO_GPIO_DEBOUNCE_EN
    mmio_gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock  (clock),
      .reset  (reset),
      .pin    (io_input_bus[g]),
      .stable (stable[g]),
      .rise   (rise[g])
    );
`else
    mmio_gpio_debounce u_db (
      .clock  (clock),
      .reset  (reset),
      .pin    (io_input_bus[g]),
      .stable (stable[g]),
      .rise   (rise[g])
    );
`endif
  end

  // Word decode; the byte-lane address bits are dropped by the shift.
  always_comb begin
    offset   = mem_addr - IO_BASE_ADDR;
    word_idx = offset >> LANE_SHIFT;
    region   = REGION_NONE;
    if (mem_addr >= IO_BASE_ADDR) begin
      if (word_idx < XLEN'(IN_BASE)) begin
        region = REGION_OUT;
      end else if (word_idx < XLEN'(EDGE_BASE)) begin
        region = REGION_IN;
      end else if (word_idx < XLEN'(NW)) begin
        region = REGION_EDGE;
      end
    end
    mem_hit = (region != REGION_NONE);
    wr      = mem_we && mem_hit;
  end

  // Combinational read mux; unstored bits and misses read as zero.
  always_comb begin
    mem_rdata = '0;
    for (int unsigned i = 0; i < IO_OUTPUT_BUS_LEN; i++) begin
      if (region == REGION_OUT && word_idx == XLEN'(i / XLEN)) begin
        mem_rdata[i % XLEN] = out_q[i];
      end
    end
    for (int unsigned i = 0; i < IO_INPUT_BUS_LEN; i++) begin
      if (region == REGION_IN && word_idx == XLEN'(IN_BASE + i / XLEN)) begin
        mem_rdata[i % XLEN] = stable[i];
      end
      if (region == REGION_EDGE && word_idx == XLEN'(EDGE_BASE + i / XLEN)) begin
        mem_rdata[i % XLEN] = edge_q[i];
      end
    end
  end

  // Byte-strobed OUT update and EDGE clear mask, resolved per bit.
  always_comb begin
    out_d    = out_q;
    edge_clr = '0;
    for (int unsigned i = 0; i < IO_OUTPUT_BUS_LEN; i++) begin
      if (wr && region == REGION_OUT && word_idx == XLEN'(i / XLEN)
          && mem_wstrb[(i % XLEN) / 8]) begin
        out_d[i] = mem_wdata[i % XLEN];
      end
    end
    for (int unsigned i = 0; i < IO_INPUT_BUS_LEN; i++) begin
      if (wr && region == REGION_EDGE && word_idx == XLEN'(EDGE_BASE + i / XLEN)
          && mem_wstrb[(i % XLEN) / 8]) begin
        edge_clr[i] = mem_wdata[i % XLEN];
      end
    end
  end

  // Output latch register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  // Edge capture: clear applied first so a same-cycle rise wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | rise;
    end
  end

  assign io_output_bus = out_q;
  assign irq           = |edge_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed test-plan steps followed by randomized bus traffic
// and pin activity, checked against a behavioural model of the GPIO block.
module tb_mmio_gpio;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IN_LEN  = 14;
  localparam int unsigned OUT_LEN = 52;
  localparam int unsigned D       = 4;
  localparam logic [31:0] BASE    = 32'h60;
`ifdef MMIO_GPIO_DEBOUNCE_EN
  localparam bit          DB_EN   = 1'b1;
  localparam int unsigned LAT     = D + 2;
`else
  localparam bit          DB_EN   = 1'b0;
  localparam int unsigned LAT     = 3;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_wstrb;
  logic                mem_we;
  logic [31:0]         mem_rdata;
  logic                mem_hit;
  logic [IN_LEN-1:0]   io_input_bus;
  logic [OUT_LEN-1:0]  io_output_bus;
  logic                irq;

  int total = 0;
  int bad   = 0;
  logic [IN_LEN-1:0] pins = '0;

  // Reference model state.
  logic [OUT_LEN-1:0] m_out    = '0;
  logic [IN_LEN-1:0]  m_stable = '0;
  logic [IN_LEN-1:0]  m_edge   = '0;
  // hist[j] holds the pin vector that was present j+1 edges before the current one.
  logic [IN_LEN-1:0]  hist [0:D];

  mmio_gpio #(
    .XLEN              (XLEN),
    .IO_INPUT_BUS_LEN  (IN_LEN),
    .IO_OUTPUT_BUS_LEN (OUT_LEN),
    .IO_BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES   (D)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .mem_hit       (mem_hit),
    .io_input_bus  (io_input_bus),
    .io_output_bus (io_output_bus),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  function automatic int word_of(input logic [31:0] a);
    if (a < BASE) return -1;
    if (((a - BASE) >> 2) >= 32'd4) return -1;
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [63:0] o;
    o = 64'(m_out);
    case (word_of(a))
      0:       return o[31:0];
      1:       return o[63:32];
      2:       return 32'(m_stable);
      3:       return 32'(m_edge);
      default: return '0;
    endcase
  endfunction

  // Model: a pin value is accepted once the synchronized stream (pin delayed
  // two edges) has disagreed with the accepted level for D consecutive edges.
  always @(posedge clock) begin : model_b
    int w;
    logic flip;
    logic e;
    logic [IN_LEN-1:0] nst;
    if (!reset) begin
      m_out    <= '0;
      m_stable <= '0;
      m_edge   <= '0;
      for (int j = 0; j <= int'(D); j++) hist[j] <= '0;
    end else begin
      w = word_of(mem_addr);
      for (int b = 0; b < int'(IN_LEN); b++) begin
        if (DB_EN) begin
          flip = 1'b1;
          for (int j = 1; j <= int'(D); j++) if (hist[j][b] == m_stable[b]) flip = 1'b0;
          nst[b] = flip ? ~m_stable[b] : m_stable[b];
        end else begin
          nst[b] = hist[1][b];
        end
      end
      for (int i = 0; i < int'(OUT_LEN); i++)
        if (mem_we && w == i / 32 && mem_wstrb[(i % 32) / 8]) m_out[i] <= mem_wdata[i % 32];
      for (int i = 0; i < int'(IN_LEN); i++) begin
        e = m_edge[i];
        if (mem_we && w == 3 + i / 32 && mem_wstrb[(i % 32) / 8] && mem_wdata[i % 32]) e = 1'b0;
        if (nst[i] && !m_stable[i]) e = 1'b1;
        m_edge[i] <= e;
      end
      m_stable <= nst;
      for (int j = int'(D); j >= 1; j--) hist[j] <= hist[j-1];
      hist[0] <= io_input_bus;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, check just after, then the
  // following rising edge commits it.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic we, input logic rst_n);
    @(negedge clock);
    mem_addr     = a;
    mem_wdata    = wd;
    mem_wstrb    = st;
    mem_we       = we;
    io_input_bus = pins;
    reset        = rst_n;
    #1;
    chk("hit",   64'(mem_hit),       64'(word_of(a) >= 0));
    chk("rdata", 64'(mem_rdata),     64'(exp_rdata(a)));
    chk("out",   64'(io_output_bus), 64'(m_out));
    chk("irq",   64'(irq),           64'(|m_edge));
  endtask

  task automatic rd(input logic [31:0] a);
    step(a, 32'h0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    step(a, wd, st, 1'b1, 1'b1);
  endtask

  initial begin
    reset        = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    mem_we       = 1'b0;
    io_input_bus = '0;
    repeat (2) @(posedge clock);

    rd(BASE);
    chk("rst_out", 64'(io_output_bus), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);

    wr(BASE, 32'hDEADBEEF, 4'hF);
    wr(BASE + 4, 32'h000FFFFF, 4'hF);
    rd(BASE + 4);
    chk("out_init", 64'(io_output_bus), 64'h000F_FFFF_DEAD_BEEF);
    chk("rd_64", 64'(mem_rdata), 64'h000F_FFFF);

    wr(BASE, 32'hFFFFFFFF, 4'hF);
    wr(BASE, 32'h0000AB00, 4'b0010);
    rd(BASE);
    chk("strobe", 64'(mem_rdata), 64'hFFFF_ABFF);

    // Pin 3 rises: nothing visible until LAT edges including the first.
    pins = 14'h0008;
    for (int i = 0; i < int'(LAT); i++) begin
      rd(BASE + 12);
      chk("pre_irq", 64'(irq), 64'd0);
    end
    rd(BASE + 12);
    chk("edge3", 64'(mem_rdata), 64'h8);
    chk("irq_set", 64'(irq), 64'd1);
    rd(BASE + 8);
    chk("in3", 64'(mem_rdata[3]), 64'd1);

    wr(BASE + 12, 32'h8, 4'hF);
    rd(BASE + 12);
    chk("w1c_irq", 64'(irq), 64'd0);
    chk("w1c_edge", 64'(mem_rdata), 64'd0);

    // Short pulse on pin 5.
    pins = 14'h0028;
    for (int i = 0; i < int'(D) - 1; i++) rd(BASE + 8);
    pins = 14'h0008;
    for (int i = 0; i < int'(D) + 3; i++) rd(BASE + 8);
`ifdef MMIO_GPIO_DEBOUNCE_EN
    chk("glitch_irq", 64'(irq), 64'd0);
    chk("glitch_in", 64'(mem_rdata), 64'h8);
`endif
    wr(BASE + 12, 32'hFFFFFFFF, 4'hF);

    // Let pin 3 fall, then clear it on the very edge its new rise is accepted.
    pins = 14'h0000;
    for (int i = 0; i < int'(LAT) + 2; i++) rd(BASE + 8);
    chk("fall_in", 64'(mem_rdata), 64'd0);
    pins = 14'h0008;
    for (int i = 0; i < int'(LAT) - 1; i++) rd(BASE + 12);
    wr(BASE + 12, 32'h8, 4'hF);
    rd(BASE + 12);
    chk("set_wins", 64'(mem_rdata), 64'h8);
    chk("set_wins_irq", 64'(irq), 64'd1);

    // Reset while pin 4 is mid-debounce.
    pins = 14'h0018;
    rd(BASE + 8);
    rd(BASE + 8);
    step(BASE + 8, 32'h0, 4'h0, 1'b0, 1'b0);
    rd(BASE + 8);
    chk("rst_mid_out", 64'(io_output_bus), 64'd0);
    chk("rst_mid_irq", 64'(irq), 64'd0);
    chk("rst_mid_in", 64'(mem_rdata), 64'd0);

    // Range boundaries.
    rd(BASE - 4);
    chk("hit_5c", 64'(mem_hit), 64'd0);
    chk("rd_5c", 64'(mem_rdata), 64'd0);
    rd(BASE + 20);
    chk("hit_74", 64'(mem_hit), 64'd0);
    chk("rd_74", 64'(mem_rdata), 64'd0);
    rd(BASE + 15);
    chk("hit_6f", 64'(mem_hit), 64'd1);

    // Randomized traffic around the decoded window.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      pins = pins ^ IN_LEN'($urandom & $urandom & $urandom);
      a = 32'h58 + 32'($urandom_range(0, 35));
      step(a, $urandom, 4'($urandom), 1'($urandom), ($urandom_range(0, 49) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
